// File: rtl/instruction_memory_loadable_if.sv
// Fetch/load bus of the loadable instruction memory: fetch request/response
// plus the run-time program-load port and the Ready indication.
interface instruction_memory_loadable_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 32
);
   localparam int LA_W = $clog2(DEPTH);

   logic                  FetchReq;
   logic [ADDR_WIDTH-1:0] Address;
   logic                  Stall;
   logic [DATA_WIDTH-1:0] ReadData;
   logic                  ReadValid;
   logic                  Fault;
   logic                  Ready;
   logic                  LoadEn;
   logic [LA_W-1:0]       LoadAddr;
   logic [DATA_WIDTH-1:0] LoadData;

   modport master (
      output FetchReq, Address, Stall, LoadEn, LoadAddr, LoadData,
      input  ReadData, ReadValid, Fault, Ready
   );

   modport slave (
      input  FetchReq, Address, Stall, LoadEn, LoadAddr, LoadData,
      output ReadData, ReadValid, Fault, Ready
   );
endinterface

// File: rtl/instruction_memory_loadable.sv
// Synchronous instruction store between fetch and decode: clears itself to
// FILL_VALUE after reset, then serves 1-cycle fetches and accepts word loads.
module instruction_memory_loadable #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DEPTH      = 32,
   parameter bit                    BYTE_ADDR  = 1'b0,
   parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
   input logic                          Clk,
   input logic                          Reset,
   instruction_memory_loadable_if.slave bus
);
   localparam int IDX_W   = $clog2(DEPTH);
   localparam int BYTE_SH = BYTE_ADDR ? $clog2(DATA_WIDTH / 8) : 0;
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << BYTE_SH) - 1);
   localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(DEPTH - 1);
   localparam logic [IDX_W:0]        DEPTH_L    = (IDX_W + 1)'(DEPTH);

   localparam logic [0:0] S_CLEAR = 1'b0;
   localparam logic [0:0] S_READY = 1'b1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [0:0]            state;
   logic [IDX_W-1:0]      clr_ptr;
   logic [DATA_WIDTH-1:0] rdata_p1;
   logic                  vld_p1;
   logic                  fault_p1;

   logic [ADDR_WIDTH-1:0] word_idx;
   logic [IDX_W-1:0]      rd_idx;
   logic                  fetch_ok;
   logic                  load_ok;

   // Upper address bits above the index field push word_idx past DEPTH, so
   // a single compare covers both out-of-range cases.
   always_comb begin
      word_idx = bus.Address >> BYTE_SH;
      rd_idx   = word_idx[IDX_W-1:0];
      fetch_ok = (word_idx < DEPTH_A) && ((bus.Address & ALIGN_MASK) == '0);
      load_ok  = ({1'b0, bus.LoadAddr} < DEPTH_L);
   end

   // Storage: clear sweep in CLEAR, program loads in READY, nothing in reset.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         if (state == S_CLEAR) begin
            mem[clr_ptr] <= FILL_VALUE;
         end else if (bus.LoadEn && load_ok) begin
            mem[bus.LoadAddr] <= bus.LoadData;
         end
      end
   end

   // Stage p1: registered fetch response; mem is read here before any same-edge load lands.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= S_CLEAR;
         clr_ptr  <= '0;
         rdata_p1 <= '0;
         vld_p1   <= 1'b0;
         fault_p1 <= 1'b0;
      end else if (state == S_CLEAR) begin
         clr_ptr <= clr_ptr + IDX_W'(1);
         if (clr_ptr == LAST_IDX) begin
            state <= S_READY;
         end
      end else if (!bus.Stall) begin
         if (bus.FetchReq) begin
            vld_p1 <= 1'b1;
            if (fetch_ok) begin
               rdata_p1 <= mem[rd_idx];
               fault_p1 <= 1'b0;
            end else begin
               rdata_p1 <= FILL_VALUE;
               fault_p1 <= 1'b1;
            end
         end else begin
            vld_p1   <= 1'b0;
            fault_p1 <= 1'b0;
         end
      end
   end

   assign bus.ReadData  = rdata_p1;
   assign bus.ReadValid = vld_p1;
   assign bus.Fault     = fault_p1;
   assign bus.Ready     = (state == S_READY);
endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Directed bench: three instances (32-word word-addressed, 20-word with a
// nonzero fill, 32-word byte-addressed) driven from one linear sequence.
module tb_instruction_memory_loadable;
   logic Clk = 1'b0;
   logic rst_a, rst_b, rst_c;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 Clk = ~Clk;

   instruction_memory_loadable_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32)) ifa ();
   instruction_memory_loadable_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(20)) ifb ();
   instruction_memory_loadable_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32)) ifc ();

   instruction_memory_loadable #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .BYTE_ADDR(1'b0), .FILL_VALUE(32'h0)
   ) dut_a (.Clk(Clk), .Reset(rst_a), .bus(ifa));

   instruction_memory_loadable #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(20), .BYTE_ADDR(1'b0), .FILL_VALUE(32'hCAFEF00D)
   ) dut_b (.Clk(Clk), .Reset(rst_b), .bus(ifb));

   instruction_memory_loadable #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .BYTE_ADDR(1'b1), .FILL_VALUE(32'hFFFFFFFF)
   ) dut_c (.Clk(Clk), .Reset(rst_c), .bus(ifc));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic [31:0] d, input logic v, input logic f);
      check({tag, "_data"}, ifa.ReadData, d);
      check({tag, "_valid"}, ifa.ReadValid, v);
      check({tag, "_fault"}, ifa.Fault, f);
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      ifa.FetchReq = 0; ifa.Address = '0; ifa.Stall = 0; ifa.LoadEn = 0; ifa.LoadAddr = '0; ifa.LoadData = '0;
      ifb.FetchReq = 0; ifb.Address = '0; ifb.Stall = 0; ifb.LoadEn = 0; ifb.LoadAddr = '0; ifb.LoadData = '0;
      ifc.FetchReq = 0; ifc.Address = '0; ifc.Stall = 0; ifc.LoadEn = 0; ifc.LoadAddr = '0; ifc.LoadData = '0;

      // Reset state
      step(); step();
      check("rst_ready", ifa.Ready, 1'b0);
      chk_a("rst", 32'h0, 1'b0, 1'b0);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

      // Clear sequence length per instance
      for (int i = 1; i <= 32; i++) begin
         step();
         check($sformatf("clr_a_ready_%0d", i), ifa.Ready, 64'(i == 32));
         check($sformatf("clr_b_ready_%0d", i), ifb.Ready, 64'(i >= 20));
         check($sformatf("clr_c_ready_%0d", i), ifc.Ready, 64'(i == 32));
      end

      // Test 1: cleared word
      ifa.FetchReq = 1; ifa.Address = 32'd5;
      step();
      chk_a("t1_fetch5", 32'h0, 1'b1, 1'b0);
      ifa.FetchReq = 0;

      // Test 2: load then fetch
      ifa.LoadEn = 1; ifa.LoadAddr = 5'd16; ifa.LoadData = 32'h20420002;
      step();
      ifa.LoadEn = 0; ifa.FetchReq = 1; ifa.Address = 32'd16;
      step();
      chk_a("t2_fetch16", 32'h20420002, 1'b1, 1'b0);

      // Test 3: same-edge load and fetch is read-before-write
      ifa.LoadEn = 1; ifa.LoadAddr = 5'd3; ifa.LoadData = 32'hDEADBEEF; ifa.Address = 32'd3;
      step();
      chk_a("t3_rbw_old", 32'h0, 1'b1, 1'b0);
      ifa.LoadEn = 0;
      step();
      chk_a("t3_rbw_new", 32'hDEADBEEF, 1'b1, 1'b0);

      // Test 4: stall holds outputs; a load during stall still lands
      ifa.Address = 32'd16;
      step();
      chk_a("t4_pre", 32'h20420002, 1'b1, 1'b0);
      ifa.Stall = 1; ifa.Address = 32'd17;
      ifa.LoadEn = 1; ifa.LoadAddr = 5'd17; ifa.LoadData = 32'hA5A50017;
      for (int i = 0; i < 3; i++) begin
         step();
         ifa.LoadEn = 0;
         chk_a($sformatf("t4_stall%0d", i), 32'h20420002, 1'b1, 1'b0);
      end
      ifa.Stall = 0;
      step();
      chk_a("t4_release", 32'hA5A50017, 1'b1, 1'b0);
      ifa.FetchReq = 0;
      step();
      chk_a("t4_idle", 32'hA5A50017, 1'b0, 1'b0);

      // Test 5: out-of-range fetches
      ifa.FetchReq = 1; ifa.Address = 32'd32;
      step();
      chk_a("t5_addr32", 32'h0, 1'b1, 1'b1);
      ifa.Address = 32'd3;
      step();
      chk_a("t5_recover", 32'hDEADBEEF, 1'b1, 1'b0);
      ifa.Address = 32'h8000_0005;
      step();
      chk_a("t5_highbits", 32'h0, 1'b1, 1'b1);
      ifa.Stall = 1; ifa.Address = 32'd3;
      step();
      chk_a("t5_fault_hold", 32'h0, 1'b1, 1'b1);
      ifa.Stall = 0; ifa.FetchReq = 0;
      step();
      chk_a("t5_fault_clr", 32'h0, 1'b0, 1'b0);

      // DEPTH=20 with nonzero fill
      ifb.FetchReq = 1; ifb.Address = 32'd19;
      step();
      check("b_last_data", ifb.ReadData, 32'hCAFEF00D);
      check("b_last_fault", ifb.Fault, 1'b0);
      ifb.Address = 32'd20;
      step();
      check("b_oor_data", ifb.ReadData, 32'hCAFEF00D);
      check("b_oor_fault", ifb.Fault, 1'b1);
      check("b_oor_valid", ifb.ReadValid, 1'b1);
      ifb.FetchReq = 0; ifb.LoadEn = 1; ifb.LoadAddr = 5'd25; ifb.LoadData = 32'h25252525;
      step();
      ifb.LoadAddr = 5'd4; ifb.LoadData = 32'h44444444;
      step();
      ifb.LoadEn = 0; ifb.FetchReq = 1; ifb.Address = 32'd4;
      step();
      check("b_load4", ifb.ReadData, 32'h44444444);
      ifb.Address = 32'd9;
      step();
      check("b_noalias9", ifb.ReadData, 32'hCAFEF00D);
      ifb.Address = 32'd5;
      step();
      check("b_noalias5", ifb.ReadData, 32'hCAFEF00D);
      ifb.FetchReq = 0;

      // Byte addressing
      ifc.LoadEn = 1; ifc.LoadAddr = 5'd16; ifc.LoadData = 32'h16161616;
      step();
      ifc.LoadEn = 0; ifc.FetchReq = 1; ifc.Address = 32'h42;
      step();
      check("c_mis42_fault", ifc.Fault, 1'b1);
      check("c_mis42_data", ifc.ReadData, 32'hFFFFFFFF);
      ifc.Address = 32'h40;
      step();
      check("c_w16_fault", ifc.Fault, 1'b0);
      check("c_w16_data", ifc.ReadData, 32'h16161616);
      ifc.Address = 32'h41;
      step();
      check("c_mis41_fault", ifc.Fault, 1'b1);
      ifc.Address = 32'h80;
      step();
      check("c_oor80_fault", ifc.Fault, 1'b1);
      ifc.Address = 32'h7C;
      step();
      check("c_w31_fault", ifc.Fault, 1'b0);
      check("c_w31_data", ifc.ReadData, 32'hFFFFFFFF);
      ifc.FetchReq = 0;

      // Test 6: reset mid-run with a load pending
      ifa.FetchReq = 1; ifa.Address = 32'd16;
      step();
      chk_a("t6_pre", 32'h20420002, 1'b1, 1'b0);
      rst_a = 1'b1; ifa.LoadEn = 1; ifa.LoadAddr = 5'd16; ifa.LoadData = 32'h12345678;
      step();
      check("t6_rst_ready", ifa.Ready, 1'b0);
      check("t6_rst_valid", ifa.ReadValid, 1'b0);
      rst_a = 1'b0; ifa.LoadEn = 0;
      for (int i = 1; i <= 32; i++) begin
         step();
         check($sformatf("t6_clr_ready_%0d", i), ifa.Ready, 64'(i == 32));
      end
      check("t6_clr_valid", ifa.ReadValid, 1'b0);
      step();
      chk_a("t6_after", 32'h0, 1'b1, 1'b0);
      ifa.FetchReq = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/instruction_memory_loadable.md
Name: instruction_memory_loadable

Overview:
Parametrised successor to the fixed 32-word instruction ROM. It is a synchronous instruction store with configurable width, depth and addressing mode, and it sits between the PC/fetch stage and the decode stage. It adds a run-time program-load port, a post-reset clear sequence, a fetch valid/stall handshake and a fault flag for out-of-range or misaligned fetches.

Parameters:
DATA_WIDTH, 32, instruction word width in bits (multiple of 8).
ADDR_WIDTH, 32, fetch address width in bits.
DEPTH, 32, number of instruction words (>=2).
BYTE_ADDR, 0, 0: Address is a word index; 1: Address is a byte address, word index = Address >> log2(DATA_WIDTH/8).
FILL_VALUE, 0, value written to every word during the clear sequence and returned on a faulting fetch.

Ports:
Clk  input  1  clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
FetchReq  input  1  fetch request for Address this cycle.
Address  input  ADDR_WIDTH  fetch address (word or byte, per BYTE_ADDR).
Stall  input  1  downstream stall; holds all fetch outputs.
ReadData  output  DATA_WIDTH  fetched instruction (registered).
ReadValid  output  1  ReadData holds the result of an accepted fetch.
Fault  output  1  the accepted fetch was out of range or misaligned; qualified by ReadValid.
Ready  output  1  clear sequence finished; fetches and loads are accepted.
LoadEn  input  1  write LoadData into word LoadAddr.
LoadAddr  input  clog2(DEPTH)  word index for the load.
LoadData  input  DATA_WIDTH  word to load.

Behaviour:
- Reset (any edge with Reset=1) sets state CLEAR, clear pointer 0, ReadData=0, ReadValid=0, Fault=0, Ready=0. Reset has priority over everything else.
- CLEAR state: each edge with Reset=0 writes FILL_VALUE to mem[ptr] and increments ptr.
  - The edge that writes index DEPTH-1 moves the state to READY, so Ready=1 after exactly DEPTH edges with Reset low.
  - FetchReq and LoadEn are ignored in CLEAR. Fetch outputs stay at their reset values.
- READY state: fetch behaviour is decided on each edge.
  - Stall=1: ReadData, ReadValid and Fault hold. FetchReq is dropped, and the requester must re-present it.
  - Stall=0, FetchReq=1: the fetch is accepted.
    - ReadValid<=1.
    - In range and aligned: ReadData<=mem[idx], Fault<=0.
    - Otherwise: ReadData<=FILL_VALUE, Fault<=1.
    - Latency is exactly 1 cycle.
  - Stall=0, FetchReq=0: ReadValid<=0, Fault<=0, ReadData holds.
- Fault conditions:
  - idx >= DEPTH, including any nonzero Address bits above the index field.
  - BYTE_ADDR=1 and the low log2(DATA_WIDTH/8) Address bits are nonzero.
- Load: in READY, LoadEn=1 writes mem[LoadAddr]<=LoadData on the edge. LoadAddr >= DEPTH is ignored with no write. Loads are independent of Stall.
- Simultaneous load and fetch to the same word: read-before-write. The fetch returns the old content, and the next fetch returns the new content.
- Reset mid-operation (during CLEAR or READY, with or without a pending load or stall) aborts everything. All loaded contents are lost and the full clear sequence restarts.
- Memory contents are indeterminate before the first reset. No initial-file preload.

Test Plan:
1. DEPTH=32, BYTE_ADDR=0; Reset high 2 cycles, then low -> Ready=0 for 31 edges and 1 after the 32nd. Fetch Address=5 -> next cycle ReadData=0x00000000, ReadValid=1, Fault=0.
2. Load LoadAddr=16, LoadData=0x20420002. Next cycle fetch Address=16 -> ReadData=0x20420002, ReadValid=1, Fault=0 one cycle later.
3. Same edge: LoadEn with LoadAddr=3, LoadData=0xDEADBEEF, and FetchReq with Address=3 -> ReadData=0x00000000. Fetch 3 again -> ReadData=0xDEADBEEF.
4. Fetch 16 (0x20420002), then Stall=1 for 3 cycles while Address=17 and FetchReq=1 -> ReadData stays 0x20420002 and ReadValid stays 1. Release Stall -> next edge returns mem[17]. Separately, FetchReq=0 with Stall=0 -> ReadValid=0.
5. Address=32 -> Fault=1, ReadValid=1, ReadData=FILL_VALUE. LoadAddr out of range cannot be driven at DEPTH=32, so use DEPTH=20 with LoadAddr=25 -> no write. With BYTE_ADDR=1: Address=0x42 -> Fault=1; Address=0x40 -> word 16 and Fault=0.
6. After test 2, assert Reset for 1 cycle mid-run with LoadEn active -> next edge Ready=0, ReadValid=0. After 32 edges Ready=1, and fetching 16 returns 0x00000000.
